// File: rtl/systolic_result_deskew_unit.sv
// Realigns diagonally skewed systolic-array result lanes into row-aligned vectors.
// Lane i is delayed by (MATRIX_WIDTH-1-i) enabled cycles; valid/address travel with lane 0.
module systolic_result_deskew_unit #(
    parameter int MATRIX_WIDTH = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic                                 valid_in,
    input  logic [ADDR_WIDTH-1:0]                addr_in,
    input  logic [MATRIX_WIDTH*DATA_WIDTH-1:0]   data_in,
    output logic [MATRIX_WIDTH*DATA_WIDTH-1:0]   data_out,
    output logic [ADDR_WIDTH-1:0]                addr_out,
    output logic                                 valid_out,
    output logic [COUNT_WIDTH-1:0]               row_count
);

    localparam int DEPTH = MATRIX_WIDTH - 1;

    // Pipes are packed vectors with stage 0 in the low slice; shifting is a
    // concat-and-truncate so a depth of 1 needs no special case.
    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH:0]                valid_ext;
    logic [DEPTH*ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [(DEPTH+1)*ADDR_WIDTH-1:0] addr_ext;
    logic [COUNT_WIDTH-1:0]        row_count_q, row_count_d;

    assign valid_ext = {valid_q, valid_in};
    assign addr_ext  = {addr_q, addr_in};

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (enable) begin
            valid_d = valid_ext[DEPTH-1:0];
            addr_d  = addr_ext[DEPTH*ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    for (genvar i = 0; i < MATRIX_WIDTH - 1; i++) begin : g_lane
        localparam int LD = MATRIX_WIDTH - 1 - i;

        logic [LD*DATA_WIDTH-1:0]     sr_q, sr_d;
        logic [(LD+1)*DATA_WIDTH-1:0] sr_ext;

        assign sr_ext = {sr_q, data_in[i*DATA_WIDTH +: DATA_WIDTH]};

        always_comb begin
            sr_d = sr_q;
            if (enable) begin
                sr_d = sr_ext[LD*DATA_WIDTH-1:0];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sr_q <= '0;
            end else begin
                sr_q <= sr_d;
            end
        end

        assign data_out[i*DATA_WIDTH +: DATA_WIDTH] = sr_q[LD*DATA_WIDTH-1 -: DATA_WIDTH];
    end

    // The last lane is already aligned when it arrives, so it passes straight through.
    assign data_out[(MATRIX_WIDTH-1)*DATA_WIDTH +: DATA_WIDTH] =
        data_in[(MATRIX_WIDTH-1)*DATA_WIDTH +: DATA_WIDTH];

    assign valid_out = enable & valid_q[DEPTH-1];
    assign addr_out  = addr_q[DEPTH*ADDR_WIDTH-1 -: ADDR_WIDTH];

    always_comb begin
        row_count_d = row_count_q;
        if (valid_out) begin
            row_count_d = row_count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_count_q <= '0;
        end else begin
            row_count_q <= row_count_d;
        end
    end

    assign row_count = row_count_q;

endmodule

// File: tb/tb_systolic_result_deskew_unit.sv
// Directed self-checking bench for systolic_result_deskew_unit (4 lanes x 8 bits, 4-bit row counter).
module tb_systolic_result_deskew_unit;

    localparam int W  = 4;
    localparam int D  = 8;
    localparam int A  = 16;
    localparam int C  = 4;

    logic           clk;
    logic           rst;
    logic           enable;
    logic           valid_in;
    logic [A-1:0]   addr_in;
    logic [W*D-1:0] data_in;
    logic [W*D-1:0] data_out;
    logic [A-1:0]   addr_out;
    logic           valid_out;
    logic [C-1:0]   row_count;

    int passed;
    int total;

    systolic_result_deskew_unit #(
        .MATRIX_WIDTH (W),
        .DATA_WIDTH   (D),
        .ADDR_WIDTH   (A),
        .COUNT_WIDTH  (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .valid_in  (valid_in),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .addr_out  (addr_out),
        .valid_out (valid_out),
        .row_count (row_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Skewed input word for cycle c: lane j carries row (c-start-j) when in range.
    // single=1 uses the 0x11,0x22,0x33,0x44 row, else lane j of row k = 16k+j.
    function automatic logic [W*D-1:0] skew(input int c, input int start, input int nrows, input bit single);
        logic [W*D-1:0] w;
        w = '0;
        for (int j = 0; j < W; j++) begin
            int k;
            k = c - start - j;
            if (k >= 0 && k < nrows) begin
                if (single) w[j*D +: D] = 8'((j + 1) * 17);
                else        w[j*D +: D] = 8'(16 * k + j);
            end
        end
        return w;
    endfunction

    function automatic logic [W*D-1:0] exp_row(input int k);
        return {8'(16 * k + 3), 8'(16 * k + 2), 8'(16 * k + 1), 8'(16 * k)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        enable   = 1'b0;
        valid_in = 1'b0;
        addr_in  = '0;
        data_in  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        enable   = 1'b1;
        valid_in = 1'b1;
        addr_in  = 16'h1234;
        data_in  = 32'hAABBCCDD;
        tick();
        tick();
        #1;
        total++;
        if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out);
        else passed++;
        total++;
        if (row_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", row_count);
        else passed++;
        total++;
        if (addr_out !== 16'h0000) $display("FAIL reset_addr: got %h want 0000", addr_out);
        else passed++;
        total++;
        if (data_out !== 32'hAA000000) $display("FAIL reset_data: got %h want aa000000", data_out);
        else passed++;
        do_reset();
    endtask

    task automatic test_single_row();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            enable   = 1'b1;
            valid_in = (c == 0);
            addr_in  = (c == 0) ? 16'h0005 : 16'h0000;
            data_in  = skew(c, 0, 1, 1'b1);
            #1;
            total++;
            if (valid_out !== (c == 3)) $display("FAIL single_valid c%0d: got %b want %b", c, valid_out, (c == 3));
            else passed++;
            if (c == 3) begin
                total++;
                if (data_out !== 32'h44332211) $display("FAIL single_data: got %h want 44332211", data_out);
                else passed++;
                total++;
                if (addr_out !== 16'h0005) $display("FAIL single_addr: got %h want 0005", addr_out);
                else passed++;
            end
            total++;
            if (row_count !== ((c >= 4) ? 4'd1 : 4'd0))
                $display("FAIL single_count c%0d: got %0d want %0d", c, row_count, (c >= 4) ? 1 : 0);
            else passed++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            enable   = 1'b1;
            valid_in = (c < 6);
            addr_in  = (c < 6) ? 16'(c) : 16'h0000;
            data_in  = skew(c, 0, 6, 1'b0);
            #1;
            total++;
            if (valid_out !== (c >= 3 && c <= 8))
                $display("FAIL b2b_valid c%0d: got %b want %b", c, valid_out, (c >= 3 && c <= 8));
            else passed++;
            if (c >= 3 && c <= 8) begin
                total++;
                if (data_out !== exp_row(c - 3)) $display("FAIL b2b_data c%0d: got %h want %h", c, data_out, exp_row(c - 3));
                else passed++;
                total++;
                if (addr_out !== 16'(c - 3)) $display("FAIL b2b_addr c%0d: got %h want %h", c, addr_out, 16'(c - 3));
                else passed++;
            end
            if (c == 9) begin
                total++;
                if (row_count !== 4'd6) $display("FAIL b2b_count: got %0d want 6", row_count);
                else passed++;
            end
            tick();
        end
    endtask

    // Two stalled cycles starting at cycle ss; input is held while stalled.
    task automatic test_stall(input int ss);
        int e;
        logic [W*D-1:0] held;
        do_reset();
        e    = 0;
        held = '0;
        for (int c = 0; c < 9; c++) begin
            bit en;
            en = !(c >= ss && c < ss + 2);
            enable = en;
            if (en) held = skew(e, 0, 1, 1'b1);
            data_in  = held;
            valid_in = en && (e == 0);
            addr_in  = (en && e == 0) ? 16'h0005 : 16'h0000;
            #1;
            total++;
            if (valid_out !== (en && e == 3))
                $display("FAIL stall%0d_valid c%0d: got %b want %b", ss, c, valid_out, (en && e == 3));
            else passed++;
            if (en && e == 3) begin
                total++;
                if (data_out !== 32'h44332211) $display("FAIL stall%0d_data: got %h want 44332211", ss, data_out);
                else passed++;
                total++;
                if (addr_out !== 16'h0005) $display("FAIL stall%0d_addr: got %h want 0005", ss, addr_out);
                else passed++;
            end
            if (!en && ss == 3) begin
                total++;
                if (data_out !== 32'h00332211) $display("FAIL stall_hold_data c%0d: got %h want 00332211", c, data_out);
                else passed++;
                total++;
                if (addr_out !== 16'h0005) $display("FAIL stall_hold_addr c%0d: got %h want 0005", c, addr_out);
                else passed++;
            end
            tick();
            if (en) e++;
        end
        total++;
        if (row_count !== 4'd1) $display("FAIL stall%0d_count: got %0d want 1", ss, row_count);
        else passed++;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            enable   = 1'b1;
            rst      = (c == 2);
            valid_in = (c == 0) || (c == 5);
            addr_in  = (c == 0) ? 16'h0003 : ((c == 5) ? 16'h0009 : 16'h0000);
            data_in  = (c <= 2) ? skew(c, 0, 1, 1'b1) : skew(c, 5, 1, 1'b1);
            #1;
            if (c != 2) begin
                total++;
                if (valid_out !== (c == 8)) $display("FAIL midrst_valid c%0d: got %b want %b", c, valid_out, (c == 8));
                else passed++;
            end
            if (c == 3) begin
                total++;
                if ((data_out & 32'h00FFFFFF) !== 32'h0) $display("FAIL midrst_lanes: got %h want 00000000 in low lanes", data_out);
                else passed++;
                total++;
                if (addr_out !== 16'h0000) $display("FAIL midrst_addr: got %h want 0000", addr_out);
                else passed++;
                total++;
                if (row_count !== 4'd0) $display("FAIL midrst_count: got %0d want 0", row_count);
                else passed++;
            end
            if (c == 8) begin
                total++;
                if (data_out !== 32'h44332211) $display("FAIL midrst_data: got %h want 44332211", data_out);
                else passed++;
                total++;
                if (addr_out !== 16'h0009) $display("FAIL midrst_addr2: got %h want 0009", addr_out);
                else passed++;
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 21; c++) begin
            enable   = 1'b1;
            valid_in = (c < 17);
            addr_in  = 16'(c);
            data_in  = skew(c, 0, 17, 1'b0);
            #1;
            if (c >= 18) begin
                total++;
                if (row_count !== 4'((c - 3) % 16))
                    $display("FAIL wrap_count c%0d: got %0d want %0d", c, row_count, (c - 3) % 16);
                else passed++;
            end
            if (c == 19) begin
                total++;
                if (valid_out !== 1'b1 || data_out !== exp_row(16))
                    $display("FAIL wrap_last_row: got %b/%h want 1/%h", valid_out, data_out, exp_row(16));
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_valid_while_stalled();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            enable   = (c >= 3);
            valid_in = (c < 3);
            addr_in  = 16'h0007;
            data_in  = 32'h01020304;
            #1;
            total++;
            if (valid_out !== 1'b0) $display("FAIL stalled_vin_valid c%0d: got %b want 0", c, valid_out);
            else passed++;
            tick();
        end
        total++;
        if (row_count !== 4'd0) $display("FAIL stalled_vin_count: got %0d want 0", row_count);
        else passed++;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        rst      = 1'b1;
        enable   = 1'b0;
        valid_in = 1'b0;
        addr_in  = '0;
        data_in  = '0;
        tick();
        test_reset();
        test_single_row();
        test_back_to_back();
        test_stall(2);
        test_stall(3);
        test_reset_midflight();
        test_wrap();
        test_valid_while_stalled();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/systolic_result_deskew_unit.md
Name: systolic_result_deskew_unit

Overview:
Realigns the diagonally skewed result vectors leaving the bottom of the systolic array back into row-aligned vectors for the accumulator/result buffer write path. It is the counterpart to the input-side skew stage: lane i of a result row arrives i enabled cycles after lane 0. The block delays lane i by (MATRIX_WIDTH-1-i) enabled cycles, so all lanes leave together. A valid flag and a result-buffer address travel with lane 0 and are delayed to match.

Parameters:
MATRIX_WIDTH, 14, number of lanes (columns); legal range >= 2
DATA_WIDTH, 32, width of one result lane (accumulator word)
ADDR_WIDTH, 16, width of the row address tag
COUNT_WIDTH, 16, width of the emitted-row counter

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
enable  input  1  advance all delay lines; low = stall/hold
valid_in  input  1  lane 0 of a new result row is present on data_in[0] this cycle
addr_in  input  ADDR_WIDTH  destination row address, sampled with valid_in
data_in  input  MATRIX_WIDTH*DATA_WIDTH  skewed lanes; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
data_out  output  MATRIX_WIDTH*DATA_WIDTH  row-aligned result vector
addr_out  output  ADDR_WIDTH  address belonging to data_out
valid_out  output  1  data_out/addr_out hold a complete aligned row
row_count  output  COUNT_WIDTH  number of rows emitted since reset

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- Lane i (0 <= i <= MATRIX_WIDTH-2): shift register of depth MATRIX_WIDTH-1-i, DATA_WIDTH wide. data_out lane i = tail of that register.
- Lane MATRIX_WIDTH-1: no register; data_out lane MATRIX_WIDTH-1 = data_in lane MATRIX_WIDTH-1, combinational.
- Valid pipe: MATRIX_WIDTH-1 stages, fed by valid_in. Address pipe: same depth, fed by addr_in. Both run in lockstep with lane 0.
- All registers shift only on cycles with enable=1. With enable=0, every register holds its value.
- valid_out = enable AND valid-pipe tail. It is forced low while stalled, because the combinational top lane is only meaningful on enabled cycles.
- addr_out = address-pipe tail, unconditionally.
- Latency: a row whose lane 0 is accepted on enabled cycle N produces valid_out on enabled cycle N+MATRIX_WIDTH-1. Non-enabled cycles are not counted.
- Throughput: one row per enabled cycle. Back-to-back valid_in rows leave back-to-back, with no bubbles and no cross-row mixing.
- valid_in is sampled only when enable=1. valid_in on a stalled cycle is ignored.
- row_count increments by 1 on every cycle with valid_out=1 and wraps modulo 2^COUNT_WIDTH. All-ones + 1 = 0, with no saturation and no flag.
- Reset: all data, address and valid registers clear to 0. Resulting output values:
  - valid_out = 0 and row_count = 0.
  - addr_out = 0.
  - data_out lanes 0..MATRIX_WIDTH-2 = 0; lane MATRIX_WIDTH-1 follows data_in.
- Reset takes priority over enable.
- Reset mid-operation: every in-flight row is discarded, and no valid_out appears for a row accepted before reset. The first valid_out after reset comes MATRIX_WIDTH-1 enabled cycles after the first post-reset valid_in.
- Data lanes are not qualified by valid. Garbage in unused lane slots propagates to data_out, and consumers must qualify with valid_out.
- No internal state machine beyond the delay lines and the counter. The block has no backpressure output; upstream stalls by deasserting enable.

Test Plan:
- W=4, D=8, enable=1, one row: lanes 0..3 = 0x11, 0x22, 0x33, 0x44 driven on cycles 0..3, valid_in=1 at cycle 0 with addr 0x0005 -> at cycle 3: valid_out=1, data_out = {0x44, 0x33, 0x22, 0x11}, addr_out = 0x0005, row_count goes to 1 on the next cycle.
- Back-to-back streaming: 6 consecutive skewed rows with row k lane j = 16*k+j and addrs 0..5 -> valid_out high on cycles 3..8, each output row exactly {16k+3 .. 16k}, addr k, row_count = 6.
- Stall: the same single row with enable=0 for 2 cycles after cycle 1, and data_in held -> valid_out low during the stall, output row correct at cycle 5, registers unchanged across the stall.
- Reset mid-flight: valid_in at cycle 0, rst=1 at cycle 2 -> valid_out never asserts for that row; registered lanes and addr_out = 0; row_count = 0.
- Counter wrap: COUNT_WIDTH=4, 17 rows streamed -> row_count sequence ends 15, 0, 1.
- valid_in asserted while enable=0 -> no row emitted; row_count unchanged.
